// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the head entry and holds its last value when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
   logic [LW-1:0]    cnt_next;
   logic             do_push, do_pop;

   assign empty    = (level == '0);
   assign full     = (level == LW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign rd_next  = rd_ptr + AW'(do_pop);
   assign cnt_next = level + LW'(do_push) - LW'(do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Head register: when the new head is the slot being written this cycle, bypass din.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_next;
         level  <= cnt_next;
         if (cnt_next != '0)
            dout <= (do_push && rd_next == wr_ptr) ? din : mem[rd_next];
      end
   end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: sync, clock filter, frame check, E0/F0 prefix folding, event FIFO.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          CLK_50,
   input  logic                          reset_en,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   output logic [7:0]                    code,
   output logic                          code_ext,
   output logic                          code_brk,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic [7:0]                    err_cnt,
   output logic                          rx_busy
);

   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1, clk_s2, dat_s1, dat_s2, filt;
   logic [FW-1:0] flt_cnt;
   logic          flip, fe;
   ps2_state_t    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg, dec_byte;
   logic          par, dec_vld, good_stop, stop_bad, timeout;
   logic [TW-1:0] to_cnt;
   logic          ext_pend, brk_pend, push, full;
   ps2_entry_t    ent_in, ent_out;

   always_ff @(posedge CLK_50) begin
      if (reset_en) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // flt_cnt counts consecutive samples disagreeing with filt; the FILTER_LEN-th one flips it.
   assign flip = (clk_s2 != filt) && (flt_cnt == FW'(FILTER_LEN - 1));
   assign fe   = flip && filt;

   always_ff @(posedge CLK_50) begin
      if (reset_en) begin
         filt    <= 1'b1;
         flt_cnt <= '0;
      end else if (clk_s2 == filt || flip) begin
         flt_cnt <= '0;
         if (flip) filt <= clk_s2;
      end else begin
         flt_cnt <= flt_cnt + FW'(1);
      end
   end

   assign good_stop = dat_s2 && (^{shreg, par});
   assign stop_bad  = fe && (state == STOP) && !good_stop;
   assign timeout   = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge CLK_50) begin
      if (reset_en || fe || state == IDLE || timeout) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + TW'(1);
   end

   always_ff @(posedge CLK_50) begin
      if (reset_en) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         rx_busy  <= 1'b0;
         dec_vld  <= 1'b0;
         dec_byte <= '0;
      end else begin
         dec_vld <= 1'b0;
         if (timeout) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
         end else if (fe) begin
            case (state)
               IDLE: if (!dat_s2) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  rx_busy <= 1'b1;
               end
               DATA: begin
                  shreg   <= {dat_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= dat_s2;
                  state <= STOP;
               end
               STOP: begin
                  state    <= IDLE;
                  rx_busy  <= 1'b0;
                  dec_vld  <= good_stop;
                  dec_byte <= shreg;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK_50) begin
      if (reset_en)                                   err_cnt <= '0;
      else if ((timeout || stop_bad) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end

   // Prefix bytes only arm flags; the next ordinary byte carries and clears them.
   assign push = dec_vld && dec_byte != PS2_EXT && dec_byte != PS2_BRK;

   always_ff @(posedge CLK_50) begin
      if (reset_en) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (dec_vld) begin
         if (dec_byte == PS2_EXT)      ext_pend <= 1'b1;
         else if (dec_byte == PS2_BRK) brk_pend <= 1'b1;
         else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK_50) begin
      if (reset_en)                 overflow <= 1'b0;
      else if (push && full && !rd_en) overflow <= 1'b1;
   end

   assign ent_in = '{ext: ext_pend, brk: brk_pend, code: dec_byte};

   sync_fifo #(
      .WIDTH ($bits(ps2_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK_50),
      .reset (reset_en),
      .push  (push),
      .din   (ent_in),
      .pop   (rd_en),
      .dout  (ent_out),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign code     = ent_out.code;
   assign code_ext = ent_out.ext;
   assign code_brk = ent_out.brk;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: scaled-down PS/2 bus model driving hand-checked scan sequences.
module tb_ps2_scan_rx;

   localparam int HALF = 20;

   logic       CLK_50 = 1'b0;
   logic       reset_en = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] code, err_cnt;
   logic       code_ext, code_brk, empty, overflow, rx_busy;
   logic [3:0] level;
   int         n_cmp = 0;
   int         n_err = 0;

   always #10 CLK_50 = ~CLK_50;

   ps2_scan_rx #(
      .FIFO_DEPTH     (8),
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (300)
   ) dut (
      .CLK_50   (CLK_50),
      .reset_en (reset_en),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd_en    (rd_en),
      .code     (code),
      .code_ext (code_ext),
      .code_brk (code_brk),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .err_cnt  (err_cnt),
      .rx_busy  (rx_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLK_50);
      #1;
   endtask

   task automatic do_reset();
      reset_en = 1'b1;
      wait_cyc(3);
      reset_en = 1'b0;
      wait_cyc(2);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
   endtask

   // mode 1: check push latency on the stop bit; mode 2: pop in the push cycle.
   // Falling edge driven at edge E0 -> fe in cycle E9..E10, push E10..E11, visible after E11.
   task automatic send_bit(input logic b, input int mode);
      ps2_data = b;
      wait_cyc(HALF/2);
      ps2_clk = 1'b0;
      if (mode == 0) wait_cyc(HALF);
      else begin
         wait_cyc(10);
         if (mode == 1) chk("lat_before", empty, 1);
         else           rd_en = 1'b1;
         wait_cyc(1);
         if (mode == 1) chk("lat_after", empty, 0);
         else           rd_en = 1'b0;
         wait_cyc(HALF - 11);
      end
      ps2_clk = 1'b1;
      wait_cyc(HALF/2);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0, input int mode = 0);
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 0);
      send_bit((~^b) ^ bad_par, 0);
      send_bit(1'b1, mode);
      wait_cyc(2*HALF);
   endtask

   initial begin
      do_reset();
      chk("rst_empty", empty, 1);
      chk("rst_level", level, 0);
      chk("rst_code", {code_ext, code_brk, code}, 10'h000);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_busy", rx_busy, 0);

      // 1: single make code with push-latency check
      send_frame(8'h1C, 1'b0, 1);
      chk("t1_head", {code_ext, code_brk, code}, {2'b00, 8'h1C});
      chk("t1_level", level, 1);
      pop();
      chk("t1_empty", empty, 1);
      chk("t1_level0", level, 0);

      // 2: prefix folding
      send_frame(8'hF0);
      send_frame(8'h1C);
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h75);
      chk("t2_level", level, 2);
      chk("t2_head0", {code_ext, code_brk, code}, {2'b01, 8'h1C});
      pop();
      chk("t2_head1", {code_ext, code_brk, code}, {2'b11, 8'h75});
      pop();
      chk("t2_empty", empty, 1);

      // 3: parity error then good frame
      do_reset();
      send_frame(8'h16, 1'b1);
      chk("t3_err_nopush", empty, 1);
      send_frame(8'h16);
      chk("t3_err", err_cnt, 1);
      chk("t3_level", level, 1);
      chk("t3_head", {code_ext, code_brk, code}, {2'b00, 8'h16});
      pop();

      // 4: partial frame, timeout, recovery
      do_reset();
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      ps2_data = 1'b1;
      chk("t4_busy", rx_busy, 1);
      wait_cyc(200);
      chk("t4_busy_hold", rx_busy, 1);
      wait_cyc(200);
      chk("t4_busy_to", rx_busy, 0);
      chk("t4_err", err_cnt, 1);
      chk("t4_noentry", empty, 1);
      send_frame(8'h45);
      chk("t4_head", {code_ext, code_brk, code}, {2'b00, 8'h45});
      chk("t4_level", level, 1);
      chk("t4_err_keep", err_cnt, 1);

      // 5: overflow, order, push+pop when full
      do_reset();
      for (int i = 1; i <= 9; i++) send_frame(8'(i));
      chk("t5_level", level, 8);
      chk("t5_ovf", overflow, 1);
      for (int i = 1; i <= 8; i++) begin
         chk("t5_order", code, i);
         pop();
      end
      chk("t5_drained", empty, 1);
      do_reset();
      for (int i = 8'h0A; i <= 8'h11; i++) send_frame(8'(i));
      chk("t5_full", level, 8);
      send_frame(8'h12, 1'b0, 2);
      chk("t5_pp_level", level, 8);
      chk("t5_pp_ovf", overflow, 0);
      for (int i = 8'h0B; i <= 8'h12; i++) begin
         chk("t5_pp_order", code, i);
         pop();
      end
      chk("t5_pp_empty", empty, 1);

      // 6: glitch rejection, then reset mid-frame
      do_reset();
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cyc(3);
      ps2_clk  = 1'b1;
      wait_cyc(20);
      chk("t6_glitch_busy", rx_busy, 0);
      ps2_data = 1'b1;
      wait_cyc(20);
      send_frame(8'h29, 1'b1);
      send_frame(8'h1C);
      send_frame(8'h32);
      send_frame(8'h21);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      ps2_data = 1'b1;
      chk("t6_pre_busy", rx_busy, 1);
      chk("t6_pre_level", level, 3);
      chk("t6_pre_err", err_cnt, 1);
      reset_en = 1'b1;
      wait_cyc(1);
      reset_en = 1'b0;
      chk("t6_empty", empty, 1);
      chk("t6_level", level, 0);
      chk("t6_err", err_cnt, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_busy", rx_busy, 0);
      send_frame(8'h4D);
      chk("t6_after", {code_ext, code_brk, code}, {2'b00, 8'h4D});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
- Front end of the keyboard time-entry path. Samples raw PS/2 clock and data on CLK_50, filters and frames 11-bit device-to-host packets, and checks start, parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into flags, then queues complete key events in a small FIFO.
- The key-to-time parser pops events from the FIFO at its own pace, so that parser never sees raw PS/2 timing.

Parameters:
- FIFO_DEPTH, 8, queue entries; must be a power of 2, minimum 2.
- FILTER_LEN, 8, consecutive equal CLK_50 samples needed before the filtered ps2_clk changes.
- TIMEOUT_CYCLES, 100000, CLK_50 cycles (2 ms) without a falling edge before a partial frame is aborted.

Ports:
- CLK_50  in  1  system clock, 50 MHz
- reset_en  in  1  synchronous reset, active-high
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- rd_en  in  1  pop request for the head entry
- code  out  8  scan code at the FIFO head
- code_ext  out  1  head entry was preceded by E0
- code_brk  out  1  head entry was preceded by F0 (key release)
- empty  out  1  FIFO empty
- level  out  log2(FIFO_DEPTH)+1  current entry count
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- err_cnt  out  8  saturating count of rejected frames
- rx_busy  out  1  frame in progress (FSM not in IDLE)

Behaviour:
- One clock domain, CLK_50. Reset is synchronous and active-high on reset_en.
- Reset values:
  - synchronizers and filter = 1 (bus idle-high);
  - FSM = IDLE; ext_pend = brk_pend = 0;
  - FIFO flushed: empty=1, level=0, code=0, code_ext=0, code_brk=0;
  - overflow=0, err_cnt=0, rx_busy=0.
- Reset mid-frame discards the partial frame.
- Input path:
  - 2-flop synchronizer on each of ps2_clk and ps2_data.
  - Clock filter: the filtered level flips only after FILTER_LEN consecutive samples that differ from the current filtered value.
  - A falling edge is filtered 1->0; it produces a 1-cycle strobe fe.
  - Data is sampled from the synchronized ps2_data in the fe cycle.
- Frame FSM (advances only on fe, except on timeout):
  - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay in IDLE (false start, not counted as an error).
  - DATA: shift in LSB first; bit_cnt 0..7; after bit 7 -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: frame is good when the stop bit = 1 and XOR(data[7:0], parity) = 1 (odd parity). Good -> decode; bad -> err_cnt+1. Either way -> IDLE.
  - Timeout: a counter resets on every fe. In any non-IDLE state, reaching TIMEOUT_CYCLES -> IDLE and err_cnt+1.
  - err_cnt saturates at 255.
- Decode, in the cycle after the good STOP (T+1):
  - byte E0: set ext_pend, no push.
  - byte F0: set brk_pend, no push.
  - any other byte: push {ext_pend, brk_pend, byte}, then clear both pend flags.
  - Pending flags persist across idle time, are cleared by reset, and are not cleared by frame errors.
- FIFO (show-ahead):
  - code, code_ext and code_brk always reflect the head entry. They are valid while empty=0 and hold their last value when empty.
  - A push at T+1 makes the entry visible (empty=0, level updated) at T+2.
  - rd_en with empty=1 is ignored.
  - Push while full with no pop: entry dropped, overflow=1 (sticky until reset).
  - Simultaneous push and pop when full: both occur, level unchanged, no overflow.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- rx_busy = (FSM != IDLE), registered.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0;
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - a packed entry typedef {ext, brk, code[7:0]}.
- One sub-module, sync_fifo: parameterised width and depth, show-ahead, with push, pop, full, empty, level. It is reused by the time-entry block later.
- Synchronizer, filter, FSM and prefix decode stay inline in ps2_scan_rx.

Test Plan:
- Bus model: 10 kHz PS/2 clock, data changes mid-high.
1. Send make code 0x1C with valid odd parity -> exactly one entry: code=1C, ext=0, brk=0. empty falls 2 cycles after the stop-bit fe. level=1. rd_en pulse -> empty=1, level=0.
2. Send F0 1C, then E0 F0 75 -> two entries only: {1C, ext=0, brk=1} then {75, ext=1, brk=1}.
3. Send 0x16 with its parity bit flipped, then a correct 0x16 -> err_cnt=1, one entry only, code=16.
4. Send start bit plus 4 data bits, then hold the clock high for more than TIMEOUT_CYCLES -> rx_busy falls at timeout, err_cnt=1, no entry. A following good 0x45 is received correctly.
5. Push 9 make codes 0x01..0x09 with no reads -> level=8, overflow=1, and pops return 01..08 in order. Refill to full, then pop on the push cycle -> level stays 8, overflow unchanged.
6. Inject a 3-cycle low glitch on ps2_clk while idle -> no fe, rx_busy=0. Then with 3 entries queued and a frame in progress, assert reset_en for 1 cycle -> empty=1, level=0, err_cnt=0, overflow=0, rx_busy=0.
